// File: rtl/spwm_gate_driver.sv
// SPWM gate driver: folds the upstream sawtooth into a triangle carrier,
// double-buffers the sine reference, compares, and drives a complementary
// gate pair with dead-time insertion.
//
// Reference handshake: a sample transfers on any clk edge where
// ref_valid && ref_ready; ref_ready is high exactly when the shadow register
// is empty, and a producer holding ref_valid while ref_ready is low keeps its
// sample until the transfer edge.
module spwm_gate_driver #(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = 255,
    parameter int DEAD    = 4,
    parameter int DTW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_syn,
    input  logic             en,
    input  logic             e,
    input  logic             carry,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] ref_data,
    input  logic             ref_valid,
    output logic             ref_ready,
    output logic             sample_req,
    output logic             dir,
    output logic             gate_h,
    output logic             gate_l,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        SAFE    = 3'd0,
        DT_H    = 3'd1,
        HIGH_ON = 3'd2,
        DT_L    = 3'd3,
        LOW_ON  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] CMAX    = WIDTH'(CNT_MAX);
    localparam logic [DTW-1:0]   DT_LOAD = DTW'(DEAD - 1);

    logic [WIDTH-1:0] carrier;
    logic             valley;
    logic             pending;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] ref_active;
    logic             pwm_cmp;
    state_t           state;
    logic [DTW-1:0]   dt_cnt;
    logic             from_safe;

    // e only acts through carry and the upstream cnt; kept for interface symmetry
    logic             unused_e;
    assign unused_e = e;

    // Triangle carrier: mirror the sawtooth on the down ramp
    assign carrier   = dir ? (CMAX - cnt) : cnt;
    assign valley    = carry & dir;
    assign ref_ready = ~pending;
    assign gate_h    = (state == HIGH_ON);
    assign gate_l    = (state == LOW_ON);
    assign fsm_state = state;

    // Carrier direction and valley sample request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir        <= 1'b0;
            sample_req <= 1'b0;
        end else if (rst_syn) begin
            dir        <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= valley;
            if (carry) dir <= ~dir;
        end
    end

    // Shadow/active reference double buffer; active only updates at a valley
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= 1'b0;
            shadow     <= '0;
            ref_active <= '0;
        end else if (rst_syn) begin
            pending    <= 1'b0;
            shadow     <= '0;
            ref_active <= '0;
        end else if (valley && pending) begin
            ref_active <= shadow;
            pending    <= 1'b0;
        end else if (ref_valid && !pending) begin
            shadow  <= ref_data;
            pending <= 1'b1;
        end
    end

    // Registered compare of reference against the carrier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cmp <= 1'b0;
        end else if (rst_syn) begin
            pwm_cmp <= 1'b0;
        end else begin
            pwm_cmp <= (ref_active > carrier);
        end
    end

    // Dead-time FSM; gates are decoded straight from the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SAFE;
            dt_cnt    <= '0;
            from_safe <= 1'b0;
        end else if (rst_syn) begin
            state     <= SAFE;
            dt_cnt    <= '0;
            from_safe <= 1'b0;
        end else if (!en) begin
            state     <= SAFE;
            from_safe <= 1'b0;
        end else begin
            case (state)
                SAFE: begin
                    dt_cnt <= DT_LOAD;
                    if (pwm_cmp) begin
                        state     <= DT_H;
                        from_safe <= 1'b0;
                    end else begin
                        state     <= DT_L;
                        from_safe <= 1'b1;
                    end
                end
                DT_H: begin
                    if (!pwm_cmp)            state  <= LOW_ON;
                    else if (dt_cnt == '0)   state  <= HIGH_ON;
                    else                     dt_cnt <= dt_cnt - 1'b1;
                end
                HIGH_ON: begin
                    if (!pwm_cmp) begin
                        state     <= DT_L;
                        dt_cnt    <= DT_LOAD;
                        from_safe <= 1'b0;
                    end
                end
                DT_L: begin
                    if (pwm_cmp) begin
                        // Low side never conducted after SAFE, so a completed
                        // dead time may hand straight over to the high side
                        if (from_safe && dt_cnt == '0) begin
                            state <= HIGH_ON;
                        end else begin
                            state  <= DT_H;
                            dt_cnt <= DT_LOAD;
                        end
                    end else if (dt_cnt == '0) begin
                        state <= LOW_ON;
                    end else begin
                        dt_cnt <= dt_cnt - 1'b1;
                    end
                end
                LOW_ON: begin
                    if (pwm_cmp) begin
                        state  <= DT_H;
                        dt_cnt <= DT_LOAD;
                    end
                end
                default: state <= SAFE;
            endcase
        end
    end

endmodule

// File: tb/tb_spwm_gate_driver.sv
// Testbench for spwm_gate_driver: randomized and directed stimulus checked
// against a cycle-level behavioural model of the carrier, buffer and gates.
module tb_spwm_gate_driver;

    localparam int WIDTH   = 4;
    localparam int CNT_MAX = 9;
    localparam int DEAD    = 2;
    localparam int DTW     = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             rst_syn   = 1'b0;
    logic             en        = 1'b0;
    logic             e         = 1'b0;
    logic             carry     = 1'b0;
    logic [WIDTH-1:0] cnt       = '0;
    logic [WIDTH-1:0] ref_data  = '0;
    logic             ref_valid = 1'b0;
    logic             ref_ready;
    logic             sample_req;
    logic             dir;
    logic             gate_h;
    logic             gate_l;
    logic [2:0]       fsm_state;

    spwm_gate_driver #(
        .WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .DEAD(DEAD), .DTW(DTW)
    ) dut (
        .clk(clk), .rst(rst), .rst_syn(rst_syn), .en(en), .e(e),
        .carry(carry), .cnt(cnt), .ref_data(ref_data), .ref_valid(ref_valid),
        .ref_ready(ref_ready), .sample_req(sample_req), .dir(dir),
        .gate_h(gate_h), .gate_l(gate_l), .fsm_state(fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model gate modes
    localparam int M_IDLE   = 0;
    localparam int M_ON_H   = 1;
    localparam int M_ON_L   = 2;
    localparam int M_WAIT_H = 3;
    localparam int M_WAIT_L = 4;

    int m_dir, m_pending, m_shadow, m_active, m_cmp, m_req;
    int m_mode, m_elapsed, m_via_idle, m_acc;
    int free_cnt = 1;
    int off_run  = 0;
    int prev_h   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_dir = 0; m_pending = 0; m_shadow = 0; m_active = 0; m_cmp = 0;
        m_req = 0; m_mode = M_IDLE; m_elapsed = 0; m_via_idle = 0; m_acc = 0;
    endfunction

    // One clock edge of the reference behaviour, all from pre-edge values
    function automatic void model_step();
        int tri_v;
        int valley;
        int n_cmp;
        tri_v  = (m_dir != 0) ? (CNT_MAX - int'(cnt)) : int'(cnt);
        valley = (carry && m_dir != 0) ? 1 : 0;
        n_cmp  = (m_active > tri_v) ? 1 : 0;
        m_acc  = 0;

        if (!en) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode     = (m_cmp != 0) ? M_WAIT_H : M_WAIT_L;
                    m_elapsed  = 1;
                    m_via_idle = (m_cmp == 0) ? 1 : 0;
                end
                M_WAIT_H: begin
                    if (m_cmp == 0)            m_mode = M_ON_L;
                    else if (m_elapsed >= DEAD) m_mode = M_ON_H;
                    else                       m_elapsed++;
                end
                M_ON_H: begin
                    if (m_cmp == 0) begin
                        m_mode = M_WAIT_L; m_elapsed = 1; m_via_idle = 0;
                    end
                end
                M_WAIT_L: begin
                    if (m_cmp != 0) begin
                        if (m_via_idle != 0 && m_elapsed >= DEAD) m_mode = M_ON_H;
                        else begin m_mode = M_WAIT_H; m_elapsed = 1; end
                    end else if (m_elapsed >= DEAD) m_mode = M_ON_L;
                    else m_elapsed++;
                end
                default: begin
                    if (m_cmp != 0) begin m_mode = M_WAIT_H; m_elapsed = 1; end
                end
            endcase
        end

        m_req = valley;
        if (valley != 0 && m_pending != 0) begin
            m_active  = m_shadow;
            m_pending = 0;
        end else if (ref_valid && m_pending == 0) begin
            m_shadow  = int'(ref_data);
            m_pending = 1;
            m_acc     = 1;
        end
        if (carry) m_dir = 1 - m_dir;
        m_cmp = n_cmp;
    endfunction

    // Compare all visible outputs with the model after each edge
    task automatic compare_outputs();
        check("gate_h", gate_h, m_mode == M_ON_H);
        check("gate_l", gate_l, m_mode == M_ON_L);
        check("ref_ready", ref_ready, m_pending == 0);
        check("sample_req", sample_req, m_req);
        check("dir", dir, m_dir);
        check("overlap", gate_h & gate_l, 0);
        if (gate_h && prev_h == 0) check("dead_h", off_run >= DEAD, 1);
        if (!gate_h && !gate_l) off_run++;
        else off_run = 0;
        prev_h = gate_h;
    endtask

    // Driver: one clock cycle with the upstream counter emulated
    task automatic tick();
        carry = (int'(cnt) == CNT_MAX) && e;
        @(posedge clk);
        if (!rst || rst_syn) model_reset();
        else model_step();
        #1;
        if (!rst || rst_syn) cnt = '0;
        else if (free_cnt != 0 && e) cnt = (int'(cnt) == CNT_MAX) ? '0 : cnt + 1'b1;
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input int data);
        ref_valid = 1'b1;
        ref_data  = WIDTH'(data);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_acc != 0) break;
        end
        ref_valid = 1'b0;
    endtask

    task automatic set_tri(input int t);
        cnt = WIDTH'((m_dir != 0) ? (CNT_MAX - t) : t);
    endtask

    // Asynchronous reset asserted between edges
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_gate_h", gate_h, 0);
        check("arst_gate_l", gate_l, 0);
        check("arst_dir", dir, 0);
        check("arst_sample_req", sample_req, 0);
        check("arst_ref_ready", ref_ready, 1);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int lows;
        int highs;
        model_reset();
        #1 rst = 1'b0;
        #2;
        check("rst_gate_h", gate_h, 0);
        check("rst_gate_l", gate_l, 0);
        check("rst_dir", dir, 0);
        check("rst_sample_req", sample_req, 0);
        check("rst_ref_ready", ref_ready, 1);
        run(2);
        rst = 1'b1;
        run(3);

        // Carrier, valley and handshake
        en = 1'b1; e = 1'b1; free_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (int'(cnt) == 3 && m_dir == 0) break;
            tick();
        end
        offer(5);
        check("hs_ready_low", ref_ready, 0);
        ref_valid = 1'b1; ref_data = WIDTH'(7);
        run(25);
        ref_valid = 1'b0;
        run(60);

        // Single-cycle compare glitch while the low side conducts
        offer(5);
        run(25);
        e = 1'b0; free_cnt = 0;
        set_tri(8); run(8);
        set_tri(2); tick();
        set_tri(8);
        lows = 0; highs = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (!gate_l) lows++;
            if (gate_h) highs++;
        end
        check("glitch_l_low", lows, 1);
        check("glitch_h", highs, 0);
        e = 1'b1; free_cnt = 1;

        // Extremes and enable
        offer(12);
        run(30);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("steady_h", gate_h, 1);
        end
        en = 1'b0; tick();
        check("en_off_h", gate_h, 0);
        en = 1'b1;
        tick(); check("en_dt1", gate_h, 0);
        tick(); check("en_dt2", gate_h, 0);
        tick(); check("en_on", gate_h, 1);
        offer(0);
        run(30);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("steady_l", gate_l, 1);
        end

        // Randomized operation
        for (int i = 0; i < 1500; i++) begin
            if (i == 1000) free_cnt = 0;
            if (free_cnt == 0) cnt = WIDTH'($urandom_range(0, CNT_MAX));
            e         = ($urandom_range(0, 9) < 8);
            ref_valid = ($urandom_range(0, 3) == 0);
            ref_data  = WIDTH'($urandom_range(0, 15));
            rst_syn   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (i == 700) async_reset();
            tick();
        end
        rst_syn = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
